// File: rtl/sisc_mem_arb.sv
// Shares one single-port memory between SISC instruction fetch and load/store.
// One access at a time; load/store has priority, bounded by a starvation streak.
module sisc_mem_arb #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant
);

    localparam int STREAK_W = $clog2(STARVE_MAX + 1);
    localparam int LAT_W    = $clog2(MEM_LAT + 1);

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_IF   = 2'b01;
    localparam logic [1:0] GRANT_LS   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                if_ack_q, if_ack_d;
    logic                ls_ack_q, ls_ack_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [LAT_W-1:0]    lat_q, lat_d;

    logic streak_full;
    logic pick_if;

    assign streak_full = (streak_q == STREAK_W'(STARVE_MAX));
    // Fetch only beats a concurrent load/store once the streak has saturated.
    assign pick_if     = if_req && (!ls_req || streak_full);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_ack_d    = 1'b0;
        ls_ack_d    = 1'b0;
        streak_d    = streak_q;
        lat_d       = lat_q;

        case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    mem_en_d = 1'b1;
                    state_d  = ACCESS;
                    if (pick_if) begin
                        grant_d    = GRANT_IF;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr;
                        streak_d   = '0;
                    end else begin
                        grant_d     = GRANT_LS;
                        mem_we_d    = ls_we;
                        mem_addr_d  = ls_addr;
                        mem_wdata_d = ls_wdata;
                        if (if_req && !streak_full) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                    end
                end
            end
            ACCESS: begin
                lat_d   = LAT_W'(MEM_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    state_d = RESP;
                    if (grant_q == GRANT_IF) begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            ls_rdata_d = mem_rdata;
                        end
                        ls_ack_d = 1'b1;
                    end
                end
            end
            RESP: begin
                grant_d = GRANT_NONE;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q     <= IDLE;
            grant_q     <= GRANT_NONE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            ls_ack_q    <= 1'b0;
            streak_q    <= '0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_ack_q    <= if_ack_d;
            ls_ack_q    <= ls_ack_d;
            streak_q    <= streak_d;
            lat_q       <= lat_d;
        end
    end

    assign grant     = grant_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign if_ack    = if_ack_q;
    assign ls_ack    = ls_ack_q;

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Scoreboard bench for sisc_mem_arb: a MEM_LAT=1 instance with a memory model,
// plus a MEM_LAT=3 instance for the long-latency load.
module tb_sisc_mem_arb;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        if_req, if_ack, ls_req, ls_we, ls_ack, mem_en, mem_we;
    logic [15:0] if_addr, ls_addr, mem_addr;
    logic [31:0] if_rdata, ls_wdata, ls_rdata, mem_wdata, mem_rdata;
    logic [1:0]  grant;

    logic        if_req3, if_ack3, ls_req3, ls_we3, ls_ack3, mem_en3, mem_we3;
    logic [15:0] if_addr3, ls_addr3, mem_addr3;
    logic [31:0] if_rdata3, ls_wdata3, ls_rdata3, mem_wdata3, mem_rdata3;
    logic [1:0]  grant3;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    typedef struct {
        bit          isLs;
        logic [31:0] data;
        int          expCyc;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sisc_mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_f(rst_f),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(ls_rdata), .ls_ack(ls_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant)
    );

    sisc_mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst_f(rst_f),
        .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_ack(if_ack3),
        .ls_req(ls_req3), .ls_we(ls_we3), .ls_addr(ls_addr3), .ls_wdata(ls_wdata3),
        .ls_rdata(ls_rdata3), .ls_ack(ls_ack3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .grant(grant3)
    );

    // Memory models drive a poison value except in the one cycle read data is valid.
    logic [31:0] mem [0:255];
    logic [31:0] rdData;
    logic        rdValid = 1'b0;
    logic [2:0]  rdValid3 = 3'b000;

    always @(posedge clk) begin
        rdValid  <= mem_en && !mem_we;
        rdValid3 <= {rdValid3[1:0], mem_en3 && !mem_we3};
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        rdData <= mem[mem_addr[7:0]];
        end
    end

    assign mem_rdata  = rdValid ? rdData : 32'h5A5A_5A5A;
    assign mem_rdata3 = rdValid3[2] ? 32'h0000_CAFE : 32'h5A5A_5A5A;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every acknowledge pops the next expected response.
    always @(negedge clk) begin
        if (if_ack && ls_ack) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL dual_ack: got if_ack=1 ls_ack=1, expected at most one (cycle %0d)", cyc);
        end else if (if_ack || ls_ack) begin
            if (sbq.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_ack: got if_ack=%0b ls_ack=%0b, expected none (cycle %0d)",
                         if_ack, ls_ack, cyc);
            end else begin
                e = sbq.pop_front();
                checkOutput({e.name, "_port"}, {31'd0, ls_ack}, {31'd0, e.isLs});
                checkOutput({e.name, "_rdata"}, ls_ack ? ls_rdata : if_rdata, e.data);
                if (e.expCyc >= 0) checkOutput({e.name, "_ackcyc"}, cyc, e.expCyc);
            end
        end
    end

    task automatic waitAck(input bit isLs, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = isLs ? ls_ack : if_ack;
        end
        if (!seen) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s_timeout: got no ack in 40 cycles, expected ack", name);
        end
    endtask

    // Single request from an idle arbiter; ack due 3 cycles after the request is seen.
    task automatic applyStimulus(input bit isLs, input bit we, input logic [15:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expData,
                                 input string name);
        int k;
        @(negedge clk);
        checkOutput({name, "_idle_grant"}, {30'd0, grant}, 32'd0);
        if (isLs) begin
            ls_req  = 1'b1;
            ls_we   = we;
            ls_addr = addr;
            if (we) ls_wdata = wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = addr;
        end
        k = cyc;
        sbq.push_back('{isLs, expData, k + 3, name});
        @(negedge clk);
        checkOutput({name, "_mem_en"}, {31'd0, mem_en}, 32'd1);
        checkOutput({name, "_grant"}, {30'd0, grant}, isLs ? 32'd2 : 32'd1);
        checkOutput({name, "_mem_addr"}, {16'd0, mem_addr}, {16'd0, addr});
        checkOutput({name, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
        if (isLs && we) checkOutput({name, "_mem_wdata"}, mem_wdata, wdata);
        waitAck(isLs, name);
        checkOutput({name, "_addr_hold"}, {16'd0, mem_addr}, {16'd0, addr});
        if_req = 1'b0;
        ls_req = 1'b0;
        ls_we  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int ackCyc;
        bit [9:0] holdPat;
        bit seen;

        rst_f = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        if_req3 = 1'b0; if_addr3 = '0;
        ls_req3 = 1'b0; ls_we3 = 1'b0; ls_addr3 = '0; ls_wdata3 = '0;
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h30] = 32'hA5A5_0030;
        mem[8'h40] = 32'h1111_0040;
        mem[8'h50] = 32'h0000_0F50;

        repeat (3) @(negedge clk);
        rst_f = 1'b0;
        checkOutput("rst_grant", {30'd0, grant}, 32'd0);
        checkOutput("rst_mem_en", {31'd0, mem_en}, 32'd0);
        checkOutput("rst_acks", {30'd0, if_ack, ls_ack}, 32'd0);
        checkOutput("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);

        $display("[TB] fetch, store, fetch-after-store");
        applyStimulus(1'b0, 1'b0, 16'h0010, 32'h0, 32'hDEAD_BEEF, "fetch10");
        applyStimulus(1'b1, 1'b1, 16'h0020, 32'h1234_5678, 32'h0, "store20");
        applyStimulus(1'b0, 1'b0, 16'h0020, 32'h0, 32'h1234_5678, "fetch20");

        $display("[TB] simultaneous requests");
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0030;
        if_req = 1'b1; if_addr = 16'h0050;
        k = cyc;
        sbq.push_back('{1'b1, 32'hA5A5_0030, k + 3, "both_ls"});
        sbq.push_back('{1'b0, 32'h0000_0F50, k + 7, "both_if"});
        @(negedge clk);
        checkOutput("both_grant", {30'd0, grant}, 32'd2);
        waitAck(1'b1, "both_ls");
        ls_req = 1'b0;
        waitAck(1'b0, "both_if");
        if_req = 1'b0;

        $display("[TB] lone loads, then both held continuously");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0040, 32'h0, 32'h1111_0040, "lone_ls");
        end
        holdPat = 10'b0111101111;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0040;
        if_req = 1'b1; if_addr = 16'h0050;
        k = cyc;
        for (int i = 0; i < 10; i++) begin
            sbq.push_back('{holdPat[i], holdPat[i] ? 32'h1111_0040 : 32'h0000_0F50,
                            k + 3 + 4 * i, holdPat[i] ? "held_ls" : "held_if"});
        end
        for (int i = 0; i < 10; i++) begin
            waitAck(holdPat[i], "held");
        end
        ls_req = 1'b0;
        if_req = 1'b0;

        $display("[TB] reset during WAIT of a fetch");
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0010;
        @(negedge clk);
        checkOutput("rstwait_mem_en", {31'd0, mem_en}, 32'd1);
        @(negedge clk);
        rst_f = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        rst_f = 1'b0;
        checkOutput("rstwait_if_ack", {31'd0, if_ack}, 32'd0);
        checkOutput("rstwait_if_rdata", if_rdata, 32'd0);
        checkOutput("rstwait_ls_rdata", ls_rdata, 32'd0);
        checkOutput("rstwait_grant", {30'd0, grant}, 32'd0);
        checkOutput("rstwait_mem_addr", {16'd0, mem_addr}, 32'd0);
        checkOutput("rstwait_mem_wdata", mem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0010, 32'h0, 32'hDEAD_BEEF, "post_rst_fetch");
        applyStimulus(1'b1, 1'b0, 16'h0040, 32'h0, 32'h1111_0040, "post_rst_load");

        $display("[TB] MEM_LAT=3 load");
        @(negedge clk);
        ls_req3 = 1'b1; ls_we3 = 1'b0; ls_addr3 = 16'h0044;
        k = cyc;
        @(negedge clk);
        checkOutput("lat3_mem_en", {31'd0, mem_en3}, 32'd1);
        checkOutput("lat3_grant", {30'd0, grant3}, 32'd2);
        seen = 1'b0;
        ackCyc = -1;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = ls_ack3;
            if (seen) ackCyc = cyc;
        end
        ls_req3 = 1'b0;
        checkOutput("lat3_ackcyc", ackCyc, k + 5);
        checkOutput("lat3_rdata", ls_rdata3, 32'h0000_CAFE);

        repeat (4) @(negedge clk);
        checkOutput("sb_empty", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/sisc_mem_arb.md
Name: sisc_mem_arb

Overview:
- Arbiter and sequencer that shares one single-port unified memory between the SISC instruction-fetch path and the load/store path.
- Accepts one request per requester, grants one access at a time and drives the memory port.
- Waits a fixed memory latency, then returns read data with a one-cycle acknowledge.
- Load/store has priority. A starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 32, memory data width
MEM_LAT, 1, memory read latency in cycles (legal range >= 1)
STARVE_MAX, 4, maximum consecutive load/store grants while fetch is waiting

Ports:
clk  input  1  system clock, rising-edge
rst_f  input  1  synchronous active-high reset
if_req  input  1  fetch request, held until if_ack
if_addr  input  ADDR_W  fetch address, stable while if_req=1
if_rdata  output  DATA_W  fetch read data, valid when if_ack=1
if_ack  output  1  fetch completion pulse
ls_req  input  1  load/store request, held until ls_ack
ls_we  input  1  1=store, 0=load, stable while ls_req=1
ls_addr  input  ADDR_W  load/store address
ls_wdata  input  DATA_W  store data
ls_rdata  output  DATA_W  load data, valid when ls_ack=1
ls_ack  output  1  load/store completion pulse
mem_en  output  1  memory access strobe, one cycle per access
mem_we  output  1  memory write enable, qualified by mem_en
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
grant  output  2  current owner: 00 none, 01 fetch, 10 load/store

Behaviour:
- All outputs are registered. Reset at a clk edge with rst_f=1:
  - state=IDLE.
  - mem_en, mem_we, if_ack, ls_ack = 0.
  - mem_addr, mem_wdata, if_rdata, ls_rdata = 0.
  - grant=00, streak counter=0, latency counter=0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
  - IDLE: if no request, stay.
  - IDLE with a request: select the winner, latch its address, data and we into mem_* and set grant. Go to ACCESS.
  - ACCESS (1 cycle): mem_en=1, mem_we=latched we. Load the latency counter with MEM_LAT. Go to WAIT.
  - WAIT: decrement the counter each cycle.
  - WAIT, last cycle (counter=1): capture mem_rdata into the winner's rdata register. Go to RESP. For stores, rdata is left unchanged.
  - RESP (1 cycle): the winner's ack=1. Go to IDLE and set grant=00.
- Latency: request first seen in IDLE at cycle 0 gives mem_en at cycle 1 and ack at cycle 2+MEM_LAT. Back-to-back accesses restart from IDLE, so throughput is one access per 3+MEM_LAT cycles.
- Arbitration, both requests in IDLE:
  - Load/store wins, unless streak==STARVE_MAX; then fetch wins.
  - Streak increments on each load/store grant made while if_req=1. It saturates at STARVE_MAX.
  - Streak clears on any fetch grant.
  - A load/store grant made while if_req=0 leaves streak unchanged.
- Single request: granted regardless of streak.
- Handshake:
  - The requester holds req and its payload stable until ack.
  - Req may be deasserted in the ack cycle, or held to request again.
  - Requests are sampled only in IDLE. Req changes during ACCESS, WAIT or RESP have no effect.
  - Payload is latched at grant, so later changes do not affect the in-flight access.
- Only one of if_ack and ls_ack is high in any cycle. Each ack is high for exactly one cycle per access.
- mem_addr, mem_wdata and mem_we hold their values after ACCESS until the next grant. mem_en is high only in ACCESS.
- Reset mid-operation (any state) aborts the access:
  - No ack is issued.
  - The captured rdata is discarded, and all reset values apply on the next cycle.
  - A store already strobed in ACCESS is not undone.

Test Plan:
- MEM_LAT=1, fetch read: memory[0x0010]=0xDEADBEEF, if_req at cycle 0 with if_addr=0x0010 -> mem_en=1, mem_addr=0x0010, grant=01 at cycle 1; if_ack=1 with if_rdata=0xDEADBEEF at cycle 3.
- Store then fetch-read the same location: ls_req, ls_we=1, ls_addr=0x0020, ls_wdata=0x12345678 -> mem_we=1 with mem_en at cycle 1, ls_ack at cycle 3; following fetch of 0x0020 -> if_rdata=0x12345678.
- Simultaneous requests in IDLE, streak=0 -> grant=10, ls_ack first; fetch granted on the next IDLE once ls_req is dropped.
- ls_req and if_req held continuously, STARVE_MAX=4 -> grants in order LS, LS, LS, LS, IF, LS...; streak returns to 0 after the IF grant.
- MEM_LAT=3, load with mem_rdata=0x0000CAFE -> mem_en at cycle 1, ls_ack at cycle 5, ls_rdata=0x0000CAFE.
- rst_f=1 for one cycle during WAIT of a fetch -> no if_ack, all outputs at reset values the next cycle; a subsequent request completes normally.
